seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative shift-add
// multiply, valid/ready handshake on both request and result sides.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic [3:0]       Outcond
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_CMP = 4'd5, OP_MOV = 4'd6, OP_SLL = 4'd7,
    OP_SRL = 4'd8, OP_SRA = 4'd9, OP_MUL = 4'd10
  } op_t;

  state_t state, state_nx;

  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] mul_a, mul_hi, mul_lo;
  logic             accept;
  logic             is_mul;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   wide;
  logic [SHW-1:0]   sh;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             mul_last;

  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign is_mul    = (ALUctl == OP_MUL);
  assign out_valid = (state == DONE);
  assign sh        = B[SHW-1:0];

  // Single-cycle result and flags from the live operands (used on acceptance).
  // Shifts run one bit wider so the last bit shifted out lands in the carry.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    case (ALUctl)
      OP_ADD: begin
        wide             = {1'b0, A} + {1'b0, B};
        {alu_c, alu_res} = wide;
        alu_v            = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        wide             = {1'b0, A} - {1'b0, B};
        {alu_c, alu_res} = wide;
        alu_v            = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_MOV: alu_res = B;
      OP_SLL: begin
        wide             = {1'b0, A} << sh;
        {alu_c, alu_res} = wide;
      end
      OP_SRL: begin
        wide             = {A, 1'b0} >> sh;
        {alu_res, alu_c} = wide;
      end
      OP_SRA: begin
        wide             = $signed({A, 1'b0}) >>> sh;
        {alu_res, alu_c} = wide;
      end
      default: ;
    endcase
  end

  // One shift-add multiply step: conditionally add multiplicand to the high
  // half, then shift the whole {hi,lo} product right by one.
  always_comb begin
    step_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_a} : '0);
    step_hi  = step_sum[WIDTH:1];
    step_lo  = {step_sum[0], mul_lo[WIDTH-1:1]};
    mul_last = (state == MULT) && (cnt == CNT_ONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = is_mul ? MULT : DONE;
      MULT: if (mul_last) state_nx = DONE;
      DONE: begin
        if (accept)         state_nx = is_mul ? MULT : DONE;
        else if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Multiplier registers, step counter and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      mul_a   <= '0;
      mul_hi  <= '0;
      mul_lo  <= '0;
      Out     <= '0;
      Outcond <= '0;
    end else begin
      if (accept && is_mul) begin
        mul_a  <= A;
        mul_hi <= '0;
        mul_lo <= B;
        cnt    <= CNT_INIT;
      end else if (state == MULT) begin
        mul_hi <= step_hi;
        mul_lo <= step_lo;
        cnt    <= cnt - CNT_ONE;
      end

      if (accept && !is_mul) begin
        Out     <= alu_res;
        Outcond <= {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
      end else if (mul_last) begin
        Out     <= step_lo;
        Outcond <= {step_lo[WIDTH-1], step_lo == '0, |step_hi, 1'b0};
      end
    end
  end

endmodule
